// File: rtl/rrf_retire.sv
// Retirement register file: committed arch->phys mapping, release FIFO that
// returns superseded physical registers to the free list, a registered restore
// pulse for mispredict recovery, and a retired-instruction counter.
module rrf_retire #(
  parameter int NUM_ARCH  = 32,
  parameter int PHYS_W    = 6,
  parameter int REL_DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         commit_valid,
  output logic                         commit_ready,
  input  logic                         commit_we,
  input  logic [4:0]                   commit_rd,
  input  logic [PHYS_W-1:0]            commit_pd,
  input  logic                         flush,
  output logic                         restore_valid,
  output logic [NUM_ARCH*PHYS_W-1:0]   rrat_map,
  output logic                         rel_valid,
  output logic [PHYS_W-1:0]            rel_idx,
  input  logic                         rel_ready,
  output logic [31:0]                  retired_cnt
);

  localparam int PTR_W = (REL_DEPTH > 1) ? $clog2(REL_DEPTH) : 1;
  localparam int CNT_W = $clog2(REL_DEPTH + 1);

  logic [PHYS_W-1:0] r_map  [NUM_ARCH];
  logic [PHYS_W-1:0] r_fifo [REL_DEPTH];
  logic [PTR_W-1:0]  r_head;
  logic [PTR_W-1:0]  r_tail;
  logic [CNT_W-1:0]  r_count;
  logic              r_restore;
  logic [31:0]       r_retired;

  logic              w_fire;
  logic              w_push;
  logic              w_pop;
  logic [PHYS_W-1:0] w_old;

  // Ready depends only on the registered count, so no input reaches it.
  assign commit_ready = (r_count < CNT_W'(REL_DEPTH));
  assign w_fire       = commit_valid && commit_ready;
  // x0 is hardwired to phys 0: commits to it neither update nor free anything.
  assign w_push       = w_fire && commit_we && (commit_rd != 5'd0);
  assign w_pop        = (r_count != '0) && rel_ready;
  // Pre-update mapping of rd is the register being superseded.
  assign w_old        = r_map[commit_rd];

  assign rel_valid     = (r_count != '0);
  assign rel_idx       = r_fifo[r_head];
  assign restore_valid = r_restore;
  assign retired_cnt   = r_retired;

  // Committed mapping: identity after reset, one write per fire.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_ARCH; i++) begin
        r_map[i] <= PHYS_W'(i);
      end
    end else if (w_push) begin
      r_map[commit_rd] <= commit_pd;
    end
  end

  // Release FIFO storage and pointers; a push into a full FIFO cannot happen.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < REL_DEPTH; i++) begin
        r_fifo[i] <= '0;
      end
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) begin
        r_fifo[r_tail] <= w_old;
        r_tail         <= r_tail + PTR_W'(1);
      end
      if (w_pop) begin
        r_head <= r_head + PTR_W'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Restore pulse trails flush by one cycle so the map already holds the
  // mispredicted instruction's own commit.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_restore <= 1'b0;
    end else begin
      r_restore <= flush;
    end
  end

  // Retired-instruction counter, wraps naturally at 2^32.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_retired <= '0;
    end else if (w_fire) begin
      r_retired <= r_retired + 32'd1;
    end
  end

  // Flatten the map onto the output bus.
  always_comb begin
    rrat_map = '0;
    for (int i = 0; i < NUM_ARCH; i++) begin
      rrat_map[i*PHYS_W +: PHYS_W] = r_map[i];
    end
  end

endmodule

// File: tb/tb_rrf_retire.sv
// Bench for rrf_retire: reference model of the map/counter plus a scoreboard
// queue of expected released registers, compared on each pop handshake.
module tb_rrf_retire;

  localparam int NA = 32;
  localparam int PW = 6;
  localparam int RD = 4;

  logic            clk = 1'b0;
  logic            rst;
  logic            commit_valid;
  logic            commit_ready;
  logic            commit_we;
  logic [4:0]      commit_rd;
  logic [PW-1:0]   commit_pd;
  logic            flush;
  logic            restore_valid;
  logic [NA*PW-1:0] rrat_map;
  logic            rel_valid;
  logic [PW-1:0]   rel_idx;
  logic            rel_ready;
  logic [31:0]     retired_cnt;

  rrf_retire #(.NUM_ARCH(NA), .PHYS_W(PW), .REL_DEPTH(RD)) dut (
    .clk(clk), .rst(rst),
    .commit_valid(commit_valid), .commit_ready(commit_ready),
    .commit_we(commit_we), .commit_rd(commit_rd), .commit_pd(commit_pd),
    .flush(flush), .restore_valid(restore_valid), .rrat_map(rrat_map),
    .rel_valid(rel_valid), .rel_idx(rel_idx), .rel_ready(rel_ready),
    .retired_cnt(retired_cnt)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  logic [PW-1:0] m_map [NA];
  logic [PW-1:0] exp_q [$];
  logic [31:0]   m_cnt;
  logic          m_restore;
  bit            m_known = 0;

  task automatic chk(input string tag, input logic [NA*PW-1:0] act, input logic [NA*PW-1:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s got=%0h want=%0h at %0t", tag, act, exp, $time);
  endtask

  function automatic logic [NA*PW-1:0] pack_map();
    logic [NA*PW-1:0] v;
    v = '0;
    for (int i = 0; i < NA; i++) v[i*PW +: PW] = m_map[i];
    return v;
  endfunction

  // One clock: model the edge from the currently driven inputs, then compare.
  task automatic step();
    bit m_ready;
    m_ready = (exp_q.size() < RD);
    if (m_known && !rst) begin
      chk("commit_ready", {191'd0, commit_ready}, {191'd0, m_ready});
      if (rel_valid && rel_ready) begin
        if (exp_q.size() == 0) chk("pop_on_empty", 1, 0);
        else chk("rel_idx_pop", {186'd0, rel_idx}, {186'd0, exp_q.pop_front()});
      end
      if (commit_valid && m_ready) begin
        m_cnt++;
        if (commit_we && commit_rd != 0) begin
          exp_q.push_back(m_map[commit_rd]);
          m_map[commit_rd] = commit_pd;
        end
      end
      m_restore = flush;
    end
    if (rst) begin
      for (int i = 0; i < NA; i++) m_map[i] = PW'(i);
      exp_q.delete();
      m_cnt     = 0;
      m_restore = 0;
      m_known   = 1;
    end
    @(posedge clk);
    #1;
    chk("restore_valid", {191'd0, restore_valid}, {191'd0, m_restore});
    chk("retired_cnt", {160'd0, retired_cnt}, {160'd0, m_cnt});
    chk("rrat_map", rrat_map, pack_map());
    chk("rel_valid", {191'd0, rel_valid}, {191'd0, (exp_q.size() != 0)});
  endtask

  task automatic drive(input bit v, input bit we, input int rd, input int pd);
    commit_valid = v;
    commit_we    = we;
    commit_rd    = 5'(rd);
    commit_pd    = PW'(pd);
  endtask

  function automatic logic [PW-1:0] map_at(input int i);
    return rrat_map[i*PW +: PW];
  endfunction

  initial begin
    bit seen;
    rst = 1; flush = 0; rel_ready = 1;
    drive(0, 0, 0, 0);
    step(); step();
    rst = 0;
    step();
    for (int i = 0; i < NA; i++) chk("reset_map", {186'd0, map_at(i)}, 192'(i));
    chk("reset_rel_valid", {191'd0, rel_valid}, 0);
    chk("reset_rel_idx", {186'd0, rel_idx}, 0);
    chk("reset_ready", {191'd0, commit_ready}, 1);
    chk("reset_cnt", {160'd0, retired_cnt}, 0);

    // Basic commit and same-rd forwarding.
    drive(1, 1, 5, 40); step();
    chk("rd5_map40", {186'd0, map_at(5)}, 40);
    chk("rd5_relidx", {186'd0, rel_idx}, 5);
    chk("rd5_cnt", {160'd0, retired_cnt}, 1);
    drive(1, 1, 5, 41); step();
    chk("rd5_map41", {186'd0, map_at(5)}, 41);
    chk("rd5_relidx40", {186'd0, rel_idx}, 40);
    drive(0, 0, 0, 0); step();

    // x0 writes and non-writing commits.
    drive(1, 1, 0, 20); step();
    drive(1, 0, 7, 21); step();
    drive(0, 0, 0, 0);
    chk("x0_map", {186'd0, map_at(0)}, 0);
    chk("we0_map", {186'd0, map_at(7)}, 7);
    chk("nowrite_rel", {191'd0, rel_valid}, 0);
    chk("nowrite_cnt", {160'd0, retired_cnt}, 4);

    // Fill the release FIFO with the free list stalled.
    rel_ready = 0;
    for (int i = 1; i <= 4; i++) begin drive(1, 1, i, 32 + i); step(); end
    drive(1, 1, 6, 37);
    step(); step();
    chk("full_ready", {191'd0, commit_ready}, 0);
    chk("full_cnt", {160'd0, retired_cnt}, 8);
    rel_ready = 1;
    seen = 0;
    for (int k = 0; k < 10 && !seen; k++) begin
      seen = commit_ready;
      step();
    end
    if (!seen) chk("accept_timeout", 0, 1);
    drive(0, 0, 0, 0);
    for (int k = 0; k < 6; k++) step();
    chk("drained", {191'd0, rel_valid}, 0);

    // Flush alongside the mispredicted commit; FIFO survives.
    rel_ready = 0;
    drive(1, 1, 1, 50); flush = 1; step();
    drive(0, 0, 0, 0); flush = 0;
    chk("flush_restore", {191'd0, restore_valid}, 1);
    chk("flush_map1", {186'd0, map_at(1)}, 50);
    step();
    chk("flush_one_cycle", {191'd0, restore_valid}, 0);
    chk("flush_fifo_kept", {186'd0, rel_idx}, 33);
    flush = 1; step(); step();
    flush = 0; step(); step();
    rel_ready = 1; step(); step();

    // Reset with FIFO occupied and a flush in flight.
    rel_ready = 0;
    drive(1, 1, 10, 1); step();
    drive(1, 1, 11, 2); step();
    drive(1, 1, 12, 3); step();
    drive(0, 0, 0, 0); flush = 1; rst = 1; step();
    rst = 0; flush = 0; rel_ready = 1;
    chk("rst_restore", {191'd0, restore_valid}, 0);
    chk("rst_rel_valid", {191'd0, rel_valid}, 0);
    chk("rst_cnt", {160'd0, retired_cnt}, 0);
    chk("rst_map12", {186'd0, map_at(12)}, 12);
    step();

    // Random traffic against the model.
    for (int k = 0; k < 300; k++) begin
      drive($urandom_range(0, 3) != 0, $urandom_range(0, 4) != 0,
            $urandom_range(0, 31), $urandom_range(0, 63));
      rel_ready = ($urandom_range(0, 2) != 0);
      flush     = ($urandom_range(0, 9) == 0);
      step();
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/rrf_retire.md
# rrf_retire

Retirement register file (architectural RAT) sitting directly downstream of the ROB head. Each cycle it accepts at most one committing instruction, updates the committed arch→phys mapping, and releases the superseded physical register to the free list through a small release FIFO. On a branch mispredict it presents a registered restore pulse so the speculative RAT can reload the committed mapping. It also keeps a retired-instruction counter for the perf-counter logs.

## Interface
Parameters:
- NUM_ARCH, 32, architectural registers (x0 included)
- PHYS_W, 6, physical register index width (64 phys regs)
- REL_DEPTH, 4, release FIFO depth (power of two, ≥2)

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- commit_valid  in  1  ROB head is committing this cycle
- commit_ready  out  1  block can accept a commit this cycle
- commit_we  in  1  committing instruction writes a register
- commit_rd  in  5  architectural destination
- commit_pd  in  PHYS_W  physical destination allocated at rename
- flush  in  1  ROB mispredict at head, one-cycle pulse
- restore_valid  out  1  RAT must reload from rrat_map this cycle
- rrat_map  out  NUM_ARCH*PHYS_W  committed mapping, entry i at bits [i*PHYS_W +: PHYS_W]
- rel_valid  out  1  freed physical register available
- rel_idx  out  PHYS_W  freed physical register
- rel_ready  in  1  free list accepts rel_idx
- retired_cnt  out  32  number of accepted commits

## Operation
- Commit accepted when commit_valid && commit_ready ("fire"). commit_ready = (release FIFO count < REL_DEPTH); no same-cycle pop bypass.
- On fire with commit_we=1 and commit_rd≠0: push old = rrat[commit_rd] (pre-update value) into release FIFO; rrat[commit_rd] ← commit_pd.
- On fire with commit_we=0 or commit_rd=0: no map update, no push. retired_cnt still increments.
- rrat[0] is constant 0 always; writes to it are ignored.
- Release FIFO: circular, head/tail pointers with wrap at REL_DEPTH, separate count. Pop on rel_valid && rel_ready. rel_valid = count≠0; rel_idx = entry at head. Simultaneous push and pop when full is not possible (commit_ready low); when count between 1 and REL_DEPTH-1, push and pop in the same cycle leave count unchanged.
- flush: restore_valid ← flush (registered, exactly one cycle later). A commit firing in the same cycle as flush (the mispredicted instruction itself, e.g. JAL/JALR) is applied first, so rrat_map during restore_valid includes it. Flush does not clear the release FIFO, retired_cnt or rrat.
- Back-to-back flushes produce back-to-back restore_valid cycles.
- retired_cnt wraps modulo 2^32.

## Timing
- Reset (rst sampled high at posedge): rrat[i] = i for all i; FIFO empty (rel_valid=0, rel_idx=0); commit_ready=1; restore_valid=0; retired_cnt=0. Reset mid-operation discards FIFO contents and any pending restore.
- rrat_map, rel_valid, rel_idx, restore_valid, retired_cnt are register outputs; commit_ready derived from registered count only (no combinational path from any input).
- Map update latency: 1 cycle (visible on rrat_map the cycle after fire).
- Release latency: freed reg visible on rel_valid the cycle after fire; FIFO throughput one push and one pop per cycle.
- Two commits to same rd in consecutive cycles: second push carries the first commit's commit_pd (forwarded via updated register, no hazard since one commit/cycle).

## Test plan
- Reset then read rrat_map -> entry i = i for i=0..31; rel_valid=0, commit_ready=1, retired_cnt=0.
- Commit rd=5, pd=40, we=1, rel_ready=1 -> next cycle rrat[5]=40, rel_valid=1 rel_idx=5, retired_cnt=1; commit rd=5 pd=41 next -> rel_idx=40, rrat[5]=41.
- Commits to rd=0 and with we=0 -> rrat unchanged, no rel_valid, retired_cnt increments per commit.
- Hold rel_ready=0, commit 4 writes (rd=1..4, pd=33..36) -> rel FIFO full, commit_ready=0; 5th commit_valid held not accepted; raise rel_ready -> pops 1,2,3,4 in order, 5th accepted once count<4.
- flush in same cycle as commit rd=1 pd=50 -> next cycle restore_valid=1 with rrat[1]=50, exactly one cycle; FIFO contents preserved.
- Assert rst while FIFO holds 3 entries and flush pending -> next cycle all outputs at reset values, no restore_valid.
